// File: rtl/imem_boot_loader.sv
// Boot-time loader: holds the core in reset, receives a length-prefixed byte
// stream, writes little-endian words into instruction memory, then releases the core.
module imem_boot_loader #(
    parameter int NUM_INST   = 128,
    parameter int ADDR_WIDTH = $clog2(NUM_INST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rstn,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_LOAD   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(NUM_INST);

    state_t                state_q;
    logic [7:0]            len_lo_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH-1:0] word_cnt_q;
    logic [1:0]            idx_q;
    logic [23:0]           buf_q;
    logic                  s_ready_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic                  core_rstn_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic        accept;
    logic [15:0] len_in;
    logic        last_word;

    assign accept    = s_valid && s_ready_q;
    assign len_in    = {s_data, len_lo_q};
    // The word counter never passes LEN-1, so comparing against LEN-1 cannot wrap.
    assign last_word = ({1'b0, word_cnt_q} == (len_q - {{ADDR_WIDTH{1'b0}}, 1'b1}));

    // Loader FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_lo_q     <= 8'd0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            idx_q        <= 2'd0;
            buf_q        <= 24'd0;
            s_ready_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            core_rstn_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q     <= S_LEN_LO;
                        s_ready_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        core_rstn_q <= 1'b0;
                    end else if (state_q == S_DONE) begin
                        // Release lags DONE entry by one cycle so the last write lands first.
                        done_q      <= 1'b1;
                        core_rstn_q <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_lo_q <= s_data;
                        state_q  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        if (len_in == 16'd0) begin
                            state_q   <= S_DONE;
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end else if (len_in > MAX_LEN) begin
                            state_q   <= S_ERROR;
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b0;
                            err_q     <= 1'b1;
                        end else begin
                            state_q    <= S_LOAD;
                            len_q      <= len_in[ADDR_WIDTH:0];
                            word_cnt_q <= '0;
                            idx_q      <= 2'd0;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        idx_q <= idx_q + 2'd1;
                        case (idx_q)
                            2'd0:    buf_q[7:0]   <= s_data;
                            2'd1:    buf_q[15:8]  <= s_data;
                            2'd2:    buf_q[23:16] <= s_data;
                            default: begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= word_cnt_q;
                                imem_wdata_q <= {s_data, buf_q};
                                word_cnt_q   <= word_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                                if (last_word) begin
                                    state_q   <= S_DONE;
                                    s_ready_q <= 1'b0;
                                    busy_q    <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    s_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rstn  = core_rstn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: basic, zero-length, oversize, backpressure,
// full-depth and reset/reload scenarios with hand-computed expectations.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        imem_we;
    logic [6:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rstn;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    logic [31:0] wr_addr_log [0:1023];
    logic [31:0] wr_data_log [0:1023];
    logic [7:0]  basic [0:9];

    imem_boot_loader #(.NUM_INST(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rstn  (core_rstn),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Log every write strobe mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt < 1024) begin
                wr_addr_log[wr_cnt] = 32'(imem_addr);
                wr_data_log[wr_cnt] = imem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Returns one cycle after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("s_ready_timeout", 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},    32'(s_ready),   32'd0);
        check({tag, "_imem_we"},    32'(imem_we),   32'd0);
        check({tag, "_imem_addr"},  32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata,     32'd0);
        check({tag, "_core_rstn"},  32'(core_rstn), 32'd0);
        check({tag, "_busy"},       32'(busy),      32'd0);
        check({tag, "_done"},       32'(done),      32'd0);
        check({tag, "_err"},        32'(err),       32'd0);
    endtask

    // Streams the basic two-word program, optionally with one idle cycle between bytes.
    task automatic basic_load(input string tag, input bit gap);
        int base;
        base = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            send_byte(basic[i]);
            if (gap && i < 9) step();
        end
        check({tag, "_we_last"},    32'(imem_we),   32'd1);
        check({tag, "_addr_last"},  32'(imem_addr), 32'd1);
        check({tag, "_ready_last"}, 32'(s_ready),   32'd0);
        check({tag, "_done_early"}, 32'(done),      32'd0);
        step();
        check({tag, "_we_off"},     32'(imem_we),   32'd0);
        check({tag, "_done"},       32'(done),      32'd1);
        check({tag, "_core_rstn"},  32'(core_rstn), 32'd1);
        check({tag, "_busy"},       32'(busy),      32'd0);
        check({tag, "_nwrites"},    32'(wr_cnt - base), 32'd2);
        check({tag, "_addr0"},      wr_addr_log[base],     32'd0);
        check({tag, "_data0"},      wr_data_log[base],     32'h0000_0013);
        check({tag, "_addr1"},      wr_addr_log[base + 1], 32'd1);
        check({tag, "_data1"},      wr_data_log[base + 1], 32'h0010_0093);
    endtask

    initial begin
        int base;
        int bad;
        basic[0] = 8'h02; basic[1] = 8'h00;
        basic[2] = 8'h13; basic[3] = 8'h00; basic[4] = 8'h00; basic[5] = 8'h00;
        basic[6] = 8'h93; basic[7] = 8'h00; basic[8] = 8'h10; basic[9] = 8'h00;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;

        // Reset, with start asserted concurrently: reset must win.
        step();
        start = 1'b1;
        step();
        check_reset_outputs("reset");
        start = 1'b0;
        rst = 1'b0;
        step();
        check("idle_ready", 32'(s_ready), 32'd0);

        // Basic load.
        pulse_start();
        check("start_ready", 32'(s_ready),   32'd1);
        check("start_busy",  32'(busy),      32'd1);
        check("start_rstn",  32'(core_rstn), 32'd0);
        basic_load("basic", 1'b0);
        step();
        check("basic_ready_after", 32'(s_ready), 32'd0);

        // Zero length, started from DONE.
        base = wr_cnt;
        pulse_start();
        check("restart_rstn", 32'(core_rstn), 32'd0);
        check("restart_done", 32'(done),      32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        check("zero_ready", 32'(s_ready), 32'd0);
        check("zero_done_early", 32'(done), 32'd0);
        step();
        check("zero_done", 32'(done),      32'd1);
        check("zero_rstn", 32'(core_rstn), 32'd1);
        check("zero_err",  32'(err),       32'd0);
        step();
        check("zero_nwrites", 32'(wr_cnt - base), 32'd0);

        // Oversize length 129.
        base = wr_cnt;
        pulse_start();
        send_byte(8'h81);
        send_byte(8'h00);
        step();
        step();
        check("over_err",     32'(err),       32'd1);
        check("over_rstn",    32'(core_rstn), 32'd0);
        check("over_ready",   32'(s_ready),   32'd0);
        check("over_busy",    32'(busy),      32'd0);
        check("over_done",    32'(done),      32'd0);
        check("over_nwrites", 32'(wr_cnt - base), 32'd0);

        // Recovery from ERROR with a backpressured stream.
        pulse_start();
        check("recover_err", 32'(err), 32'd0);
        basic_load("bp", 1'b1);

        // Full depth: 128 words, word i = i.
        base = wr_cnt;
        pulse_start();
        send_byte(8'h80);
        send_byte(8'h00);
        for (int i = 0; i < 128; i++) begin
            send_byte(8'(i));
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h00);
        end
        check("full_ready_end", 32'(s_ready), 32'd0);
        step();
        check("full_done", 32'(done),      32'd1);
        check("full_rstn", 32'(core_rstn), 32'd1);
        repeat (4) step();
        check("full_nwrites", 32'(wr_cnt - base), 32'd128);
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (wr_addr_log[base + i] !== 32'(i) || wr_data_log[base + i] !== 32'(i)) bad++;
        end
        check("full_word_errors", 32'(bad), 32'd0);
        check("full_last_addr", wr_addr_log[base + 127], 32'd127);

        // Reset after 5 stream bytes.
        base = wr_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(basic[i]);
        rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        rst = 1'b0;
        step();
        check("midrst_nwrites", 32'(wr_cnt - base), 32'd0);

        // Good load, then start in DONE drops the core reset and reloads from 0.
        pulse_start();
        basic_load("reload1", 1'b0);
        step();
        pulse_start();
        check("reload_rstn", 32'(core_rstn), 32'd0);
        check("reload_done", 32'(done),      32'd0);
        basic_load("reload2", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
